// File: rtl/jtframe_debug_keys.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_debug_keys
// Brief    : PS/2 set-2 scan byte decoder for debug keys. Tracks held levels
//            for shift, ctrl, keypad +/-/*, F1..F4 and digits 1..8, with
//            independent autorepeat gaps on keypad + and -.
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_debug_keys #(
  parameter int REP_DLY = 24000000,
  parameter int REP_PER = 4800000,
  parameter int TIMEOUT = 48000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ps2_code,
  input  logic       ps2_valid,
  output logic       shift,
  output logic       ctrl,
  output logic       debug_plus,
  output logic       debug_minus,
  output logic       debug_rst,
  output logic [3:0] key_gfx,
  output logic [7:0] key_digit
);

  // Held-bit layout
  localparam int NK      = 19;
  localparam int K_SHL   = 0;
  localparam int K_SHR   = 1;
  localparam int K_CTL   = 2;
  localparam int K_CTR   = 3;
  localparam int K_PLUS  = 4;
  localparam int K_MINUS = 5;
  localparam int K_RST   = 6;
  localparam int K_GFX   = 7;
  localparam int K_DIG   = 11;

  // Repeat counter never exceeds REP_DLY+REP_PER-1; keep it at least 24 bits
  localparam int REP_BITS = $clog2(REP_DLY + REP_PER + 1);
  localparam int CW       = (REP_BITS > 24) ? REP_BITS : 24;
  localparam logic [CW-1:0] c_rep_dly  = CW'(REP_DLY);
  localparam logic [CW-1:0] c_rep_wrap = CW'(REP_DLY + REP_PER - 1);

  // Timeout counter spans 0..TIMEOUT-1
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXT    = 3'd1,
    ST_BRK    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_SKIP   = 3'd4
  } state_t;

  state_t          state_q;
  logic [2:0]      skip_q;
  logic [TW-1:0]   tmo_q;
  logic [NK-1:0]   held_q;
  logic [NK-1:0]   held_d;

  logic            w_evt;
  logic            w_brk;
  logic            w_ext;
  logic            w_ovf;
  logic [NK-1:0]   w_hit;
  logic [1:0]      w_gap;

  logic            shift_q;
  logic            ctrl_q;
  logic            plus_q;
  logic            minus_q;
  logic            rst_q;
  logic [3:0]      gfx_q;
  logic [7:0]      digit_q;

  // Classify the incoming byte into make/break/overflow events for this state
  always_comb begin
    w_evt = 1'b0;
    w_brk = 1'b0;
    w_ext = 1'b0;
    w_ovf = 1'b0;
    if (ps2_valid) begin
      case (state_q)
        ST_IDLE: begin
          case (ps2_code)
            8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
            8'h00, 8'hFF: w_ovf = 1'b1;
            default:      w_evt = 1'b1;
          endcase
        end
        ST_EXT: begin
          if (ps2_code != 8'hF0) begin
            w_evt = 1'b1;
            w_ext = 1'b1;
          end
        end
        ST_BRK: begin
          w_evt = 1'b1;
          w_brk = 1'b1;
        end
        ST_EXTBRK: begin
          w_evt = 1'b1;
          w_brk = 1'b1;
          w_ext = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Map a scan code to its held bit; only E0 14 survives among extended codes
  always_comb begin
    w_hit = '0;
    if (w_ext) begin
      if (ps2_code == 8'h14) w_hit[K_CTR] = 1'b1;
    end else begin
      case (ps2_code)
        8'h12:   w_hit[K_SHL]     = 1'b1;
        8'h59:   w_hit[K_SHR]     = 1'b1;
        8'h14:   w_hit[K_CTL]     = 1'b1;
        8'h79:   w_hit[K_PLUS]    = 1'b1;
        8'h7B:   w_hit[K_MINUS]   = 1'b1;
        8'h7C:   w_hit[K_RST]     = 1'b1;
        8'h05:   w_hit[K_GFX + 0] = 1'b1;
        8'h06:   w_hit[K_GFX + 1] = 1'b1;
        8'h04:   w_hit[K_GFX + 2] = 1'b1;
        8'h0C:   w_hit[K_GFX + 3] = 1'b1;
        8'h16:   w_hit[K_DIG + 0] = 1'b1;
        8'h1E:   w_hit[K_DIG + 1] = 1'b1;
        8'h26:   w_hit[K_DIG + 2] = 1'b1;
        8'h25:   w_hit[K_DIG + 3] = 1'b1;
        8'h2E:   w_hit[K_DIG + 4] = 1'b1;
        8'h36:   w_hit[K_DIG + 5] = 1'b1;
        8'h3D:   w_hit[K_DIG + 6] = 1'b1;
        8'h3E:   w_hit[K_DIG + 7] = 1'b1;
        default: ;
      endcase
    end
  end

  // Next held-bit vector: overflow wipes everything, events set or clear
  always_comb begin
    held_d = held_q;
    if (w_ovf) begin
      held_d = '0;
    end else if (w_evt) begin
      held_d = w_brk ? (held_q & ~w_hit) : (held_q | w_hit);
    end
  end

  // Prefix FSM with skip count, inactivity timeout and held-bit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      skip_q  <= 3'd0;
      tmo_q   <= '0;
      held_q  <= '0;
    end else begin
      held_q <= held_d;
      if (ps2_valid) begin
        tmo_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (ps2_code == 8'hE0) begin
              state_q <= ST_EXT;
            end else if (ps2_code == 8'hF0) begin
              state_q <= ST_BRK;
            end else if (ps2_code == 8'hE1) begin
              state_q <= ST_SKIP;
              skip_q  <= 3'd7;
            end
          end
          ST_EXT: begin
            state_q <= (ps2_code == 8'hF0) ? ST_EXTBRK : ST_IDLE;
          end
          ST_SKIP: begin
            if (skip_q == 3'd1) begin
              state_q <= ST_IDLE;
              skip_q  <= 3'd0;
            end else begin
              skip_q <= skip_q - 3'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE) begin
        if (tmo_q == c_tmo_last) begin
          state_q <= ST_IDLE;
          skip_q  <= 3'd0;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  // Per-key hold counters for + and -; wrap back to REP_DLY every REP_PER
  for (genvar gi = 0; gi < 2; gi++) begin : g_rep
    localparam int K = K_PLUS + gi;
    logic [CW-1:0] cnt_q;

    // Count while held across consecutive cycles, clear otherwise
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (!held_q[K] || !held_d[K]) begin
        cnt_q <= '0;
      end else if (cnt_q == c_rep_wrap) begin
        cnt_q <= c_rep_dly;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    assign w_gap[gi] = (cnt_q == c_rep_dly);
  end

  // Registered output levels derived from the held bits one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 1'b0;
      ctrl_q  <= 1'b0;
      plus_q  <= 1'b0;
      minus_q <= 1'b0;
      rst_q   <= 1'b0;
      gfx_q   <= 4'd0;
      digit_q <= 8'd0;
    end else begin
      shift_q <= held_q[K_SHL] | held_q[K_SHR];
      ctrl_q  <= held_q[K_CTL] | held_q[K_CTR];
      plus_q  <= held_q[K_PLUS] & ~w_gap[0];
      minus_q <= held_q[K_MINUS] & ~w_gap[1];
      rst_q   <= held_q[K_RST];
      gfx_q   <= held_q[K_GFX +: 4];
      digit_q <= held_q[K_DIG +: 8];
    end
  end

  assign shift       = shift_q;
  assign ctrl        = ctrl_q;
  assign debug_plus  = plus_q;
  assign debug_minus = minus_q;
  assign debug_rst   = rst_q;
  assign key_gfx     = gfx_q;
  assign key_digit   = digit_q;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_debug_keys.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_debug_keys
// Brief    : Directed and random byte streams for jtframe_debug_keys, checked
//            against a prefix-queue reference model of the key decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_debug_keys;

  localparam int D   = 10;
  localparam int P   = 4;
  localparam int TMO = 20;

  logic       clk;
  logic       rst_n;
  logic [7:0] ps2_code;
  logic       ps2_valid;
  logic       shift;
  logic       ctrl;
  logic       debug_plus;
  logic       debug_minus;
  logic       debug_rst;
  logic [3:0] key_gfx;
  logic [7:0] key_digit;
  logic [16:0] dut_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [18:0] mheld;
  int          mt [2];
  int          edge_n;
  int          skip_left;
  int          idle_cnt;
  logic [7:0]  pfx [$];

  jtframe_debug_keys #(
    .REP_DLY (D),
    .REP_PER (P),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_code    (ps2_code),
    .ps2_valid   (ps2_valid),
    .shift       (shift),
    .ctrl        (ctrl),
    .debug_plus  (debug_plus),
    .debug_minus (debug_minus),
    .debug_rst   (debug_rst),
    .key_gfx     (key_gfx),
    .key_digit   (key_digit)
  );

  assign dut_out = {shift, ctrl, debug_plus, debug_minus, debug_rst, key_gfx, key_digit};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index of the held bit a plain scan code controls, -1 when unmapped
  function automatic int key_index(input logic [7:0] c);
    case (c)
      8'h12: return 0;
      8'h59: return 1;
      8'h14: return 2;
      8'h79: return 4;
      8'h7B: return 5;
      8'h7C: return 6;
      8'h05: return 7;
      8'h06: return 8;
      8'h04: return 9;
      8'h0C: return 10;
      8'h16: return 11;
      8'h1E: return 12;
      8'h26: return 13;
      8'h25: return 14;
      8'h2E: return 15;
      8'h36: return 16;
      8'h3D: return 17;
      8'h3E: return 18;
      default: return -1;
    endcase
  endfunction

  // Gap cycle when the hold time hits REP_DLY, then every REP_PER after
  function automatic bit is_gap(input int h);
    if (h < D) return 1'b0;
    return ((h - D) % P) == 0;
  endfunction

  function automatic logic [16:0] model_out();
    logic p, m;
    p = mheld[4] && !is_gap(edge_n - mt[0]);
    m = mheld[5] && !is_gap(edge_n - mt[1]);
    return {mheld[0] | mheld[1], mheld[2] | mheld[3], p, m, mheld[6],
            mheld[10:7], mheld[18:11]};
  endfunction

  task automatic model_reset();
    mheld = '0;
    pfx.delete();
    skip_left = 0;
    idle_cnt = 0;
  endtask

  task automatic press(input logic [7:0] c, input bit ext, input bit make);
    int k;
    k = ext ? ((c == 8'h14) ? 3 : -1) : key_index(c);
    if (k < 0) return;
    if (make) begin
      if (!mheld[k]) begin
        mheld[k] = 1'b1;
        if (k == 4) mt[0] = edge_n;
        if (k == 5) mt[1] = edge_n;
      end
    end else begin
      mheld[k] = 1'b0;
    end
  endtask

  // Apply one clock edge (with or without a byte) to the model
  task automatic model_edge(input logic [7:0] c, input bit v);
    if (!v) begin
      if (pfx.size() > 0 || skip_left > 0) begin
        idle_cnt++;
        if (idle_cnt >= TMO) begin
          pfx.delete();
          skip_left = 0;
          idle_cnt = 0;
        end
      end
      return;
    end
    idle_cnt = 0;
    if (skip_left > 0) begin
      skip_left--;
    end else if (pfx.size() == 0) begin
      if (c == 8'hE0 || c == 8'hF0) pfx.push_back(c);
      else if (c == 8'hE1) skip_left = 7;
      else if (c == 8'h00 || c == 8'hFF) mheld = '0;
      else if (c == 8'hAA || c == 8'hFA || c == 8'hEE || c == 8'hFE) ;
      else press(c, 1'b0, 1'b1);
    end else if (pfx.size() == 1 && pfx[0] == 8'hE0) begin
      if (c == 8'hF0) pfx.push_back(c);
      else begin
        press(c, 1'b1, 1'b1);
        pfx.delete();
      end
    end else begin
      press(c, pfx[0] == 8'hE0, 1'b0);
      pfx.delete();
    end
  endtask

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, clock, then compare all outputs to the model
  task automatic tick(input logic [7:0] c, input bit v, input string tag);
    logic [16:0] exp;
    ps2_code  = c;
    ps2_valid = v;
    exp = model_out();
    @(posedge clk);
    edge_n++;
    model_edge(c, v);
    #1;
    ps2_valid = 1'b0;
    chk(tag, dut_out, exp);
  endtask

  task automatic send(input logic [7:0] c, input string tag);
    tick(c, 1'b1, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(8'h00, 1'b0, tag);
  endtask

  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", dut_out, 17'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] pool [26];

  initial begin
    rst_n     = 1'b0;
    ps2_code  = 8'h00;
    ps2_valid = 1'b0;
    edge_n    = 0;
    mt[0]     = 0;
    mt[1]     = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", dut_out, 17'd0);
    rst_n = 1'b1;
    idle(2, "post_reset");

    // Digit 1 make then break
    send(8'h16, "dig_make");
    idle(1, "dig_make_lat");
    chk("digit1_set", {9'd0, key_digit}, 17'h01);
    send(8'hF0, "dig_f0");
    send(8'h16, "dig_brk");
    idle(1, "dig_brk_lat");
    chk("digit1_clr", {9'd0, key_digit}, 17'h00);

    // Left and right ctrl tracked separately
    send(8'h14, "lctl");
    send(8'hE0, "rctl_e0");
    send(8'h14, "rctl");
    idle(1, "ctl_lat");
    chk("ctrl_both", {16'd0, ctrl}, 17'd1);
    send(8'hE0, "rctl_brk_e0");
    send(8'hF0, "rctl_brk_f0");
    send(8'h14, "rctl_brk");
    idle(1, "ctl_lat2");
    chk("ctrl_left_only", {16'd0, ctrl}, 17'd1);
    send(8'hF0, "lctl_brk_f0");
    send(8'h14, "lctl_brk");
    idle(1, "ctl_lat3");
    chk("ctrl_released", {16'd0, ctrl}, 17'd0);

    // Keypad + autorepeat: gaps at hold counts 10,14,18,22,26
    send(8'h79, "plus_make");
    for (int h = 0; h < 30; h++) begin
      tick(8'h00, 1'b0, "plus_hold");
      chk("plus_repeat", {16'd0, debug_plus},
          {16'd0, !(h == 10 || h == 14 || h == 18 || h == 22 || h == 26)});
    end
    send(8'hF0, "plus_brk_f0");
    send(8'h79, "plus_brk");
    idle(2, "plus_rel");
    chk("plus_released", {16'd0, debug_plus}, 17'd0);

    // Both keys held together plus a typematic resend of +
    send(8'h79, "both_plus");
    idle(3, "both_gap");
    send(8'h7B, "both_minus");
    idle(5, "both_hold");
    send(8'h79, "plus_resend");
    idle(20, "both_hold2");
    send(8'hF0, "both_brk_f0");
    send(8'h79, "both_brk_plus");
    idle(6, "minus_alone");
    send(8'hF0, "minus_brk_f0");
    send(8'h7B, "minus_brk");
    idle(2, "minus_rel");

    // Fake shift and Pause sequence produce nothing; F1 afterwards works
    send(8'hE0, "fake_e0");
    send(8'h12, "fake_shift");
    idle(1, "fake_lat");
    chk("fake_shift_ignored", {16'd0, shift}, 17'd0);
    send(8'hE1, "pause_e1");
    send(8'h14, "pause_1");
    send(8'h77, "pause_2");
    send(8'hE1, "pause_3");
    send(8'hF0, "pause_4");
    send(8'h14, "pause_5");
    send(8'hF0, "pause_6");
    send(8'h77, "pause_7");
    idle(1, "pause_lat");
    chk("pause_no_events", dut_out, 17'd0);
    send(8'h05, "f1_make");
    idle(1, "f1_lat");
    chk("f1_after_pause", {13'd0, key_gfx}, 17'h1);

    // Prefix timeout: F0 then silence makes the next byte a make
    send(8'hF0, "tmo_f0");
    idle(25, "tmo_wait");
    send(8'h0C, "tmo_f4");
    idle(1, "tmo_lat");
    chk("timeout_make", {16'd0, key_gfx[3]}, 17'd1);
    send(8'hF0, "short_f0");
    idle(5, "short_wait");
    send(8'h0C, "short_f4");
    idle(1, "short_lat");
    chk("no_timeout_break", {16'd0, key_gfx[3]}, 17'd0);

    // Overflow clears every held key
    send(8'h16, "ovf_dig");
    send(8'h7C, "ovf_rst");
    send(8'h79, "ovf_plus");
    idle(1, "ovf_lat");
    chk("debug_rst_set", {16'd0, debug_rst}, 17'd1);
    send(8'h00, "ovf_byte");
    idle(1, "ovf_lat2");
    chk("overflow_clear", dut_out, 17'd0);

    // Reset after E0 discards the prefix
    send(8'hE0, "rst_e0");
    pulse_reset();
    send(8'h14, "rst_ctl");
    idle(1, "rst_lat");
    chk("ctrl_after_reset", {16'd0, ctrl}, 17'd1);
    send(8'hE0, "rst_e0b");
    pulse_reset();
    send(8'h16, "rst_dig");
    idle(1, "rst_lat2");
    chk("digit_after_reset", {9'd0, key_digit}, 17'h01);

    // Random byte stream against the model
    pool = '{8'h12, 8'h59, 8'h14, 8'h79, 8'h7B, 8'h7C, 8'h05, 8'h06, 8'h04,
             8'h0C, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
             8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hE1, 8'hAA, 8'h33, 8'hFF};
    for (int n = 0; n < 400; n++) begin
      send(pool[$urandom_range(0, 25)], "rand_byte");
      idle($urandom_range(0, 12), "rand_idle");
    end
    idle(TMO + 2, "final_drain");
    send(8'h00, "final_ovf");
    idle(1, "final_lat");
    chk("final_clear", dut_out, 17'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
